// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester fp add/sub scheduler.
package fp_addsub_arbiter_pkg;

    localparam int unsigned FP_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic req_id_t;

    // Issue stage: operands waiting for the shared datapath
    typedef struct packed {
        logic            valid;
        req_id_t         id;
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            op;
    } issue_t;

    // Response stage: captured datapath result tagged with its requester
    typedef struct packed {
        logic            valid;
        req_id_t         id;
        logic [FP_W-1:0] result;
        logic            cout;
    } resp_t;

endpackage

// File: rtl/fp_addsub_arbiter_rr_arb2.sv
// Two-way round-robin ready generation; each ready depends only on the other
// requester's valid, the priority bit and the enable.
module fp_addsub_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] ready_c
);

    always_comb begin
        ready_c = 2'b00;
        if (en) begin
            ready_c[0] = !valid[1] || !prio;
            ready_c[1] = !valid[0] ||  prio;
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin scheduler sharing one combinational fp add/sub datapath between
// two requesters through an issue register and a tagged response register.
module fp_addsub_arbiter
    import fp_addsub_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FP_W-1:0]  req0_a,
    input  logic [FP_W-1:0]  req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FP_W-1:0]  req1_a,
    input  logic [FP_W-1:0]  req1_b,
    input  logic             req1_op,
    output logic [FP_W-1:0]  dp_a,
    output logic [FP_W-1:0]  dp_b,
    output logic             dp_op,
    output logic             dp_cin,
    input  logic [FP_W-1:0]  dp_fout,
    input  logic             dp_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [FP_W-1:0]  rsp_result,
    output logic             rsp_cout,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    issue_t     s1;
    resp_t      s2;
    logic       prio;
    logic       s2_free_c;
    logic       s1_adv_c;
    logic       s1_free_c;
    logic [1:0] ready_c;
    logic       gnt0_c;
    logic       gnt1_c;
    logic       rsp_fire_c;

    // Stage advance: S2 can take a result when empty or draining this cycle
    always_comb begin
        s2_free_c  = !s2.valid || rsp_ready;
        s1_adv_c   = s1.valid && s2_free_c;
        s1_free_c  = !s1.valid || s1_adv_c;
        gnt0_c     = req0_valid && ready_c[0];
        gnt1_c     = req1_valid && ready_c[1];
        rsp_fire_c = s2.valid && rsp_ready;
    end

    fp_addsub_arbiter_rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .prio    (prio),
        .en      (s1_free_c),
        .ready_c (ready_c)
    );

    // Issue register and round-robin pointer; prio moves only on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '{valid: 1'b0, id: 1'b0, a: '0, b: '0, op: OP_ADD};
            prio <= 1'b0;
        end else if (gnt0_c) begin
            s1   <= '{valid: 1'b1, id: 1'b0, a: req0_a, b: req0_b, op: req0_op};
            prio <= 1'b1;
        end else if (gnt1_c) begin
            s1   <= '{valid: 1'b1, id: 1'b1, a: req1_a, b: req1_b, op: req1_op};
            prio <= 1'b0;
        end else if (s1_adv_c) begin
            s1.valid <= 1'b0;
        end
    end

    // Response register captures the datapath output as S1 advances
    always_ff @(posedge clk) begin
        if (rst) begin
            s2 <= '0;
        end else if (s1_adv_c) begin
            s2 <= '{valid: 1'b1, id: s1.id, result: dp_fout, cout: dp_cout};
        end else if (rsp_fire_c) begin
            s2.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_fire_c) begin
            if (s2.id == 1'b0) cnt0 <= cnt0 + CNT_W'(1);
            else               cnt1 <= cnt1 + CNT_W'(1);
        end
    end

    assign req0_ready = ready_c[0];
    assign req1_ready = ready_c[1];
    assign dp_a       = s1.a;
    assign dp_b       = s1.b;
    assign dp_op      = s1.op;
    assign dp_cin     = 1'b0;
    assign rsp_valid  = s2.valid;
    assign rsp_id     = s2.id;
    assign rsp_result = s2.result;
    assign rsp_cout   = s2.cout;
    assign busy       = s1.valid | s2.valid;

endmodule
